im_program_loader: RTL



---
 rtl/im_program_loader_pkg.sv | 13 +
 rtl/im_program_loader_byte_word_assembler.sv | 39 +++
 rtl/im_program_loader.sv | 136 +++++++++++++
 3 files changed

// File: rtl/im_program_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
package im_program_loader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        LOAD   = 2'd2
    } state_e;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_IDX_W     = 2;

endpackage

// File: rtl/im_program_loader_byte_word_assembler.sv
// Collects little-endian bytes into a word; shared by the header and payload phases.
module im_program_loader_byte_word_assembler
    import im_program_loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            rx_byte,
    input  logic                  strobe,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] word_c,
    output logic                  word_complete_c
);

    localparam int unsigned SHIFT_W = DATA_WIDTH - 8;

    logic [BYTE_IDX_W-1:0] byte_idx;
    logic [SHIFT_W-1:0]    shift_q;

    // Earlier bytes shift down so the newest byte always lands in the top lane.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byte_idx <= '0;
            shift_q  <= '0;
        end else if (clear) begin
            byte_idx <= '0;
            shift_q  <= '0;
        end else if (strobe) begin
            byte_idx <= byte_idx + BYTE_IDX_W'(1);
            shift_q  <= {rx_byte, shift_q[SHIFT_W-1:8]};
        end
    end

    // The completed word is presented in the same cycle as its final byte.
    assign word_c          = {rx_byte, shift_q};
    assign word_complete_c = strobe && (byte_idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/im_program_loader.sv
// Loads a length-prefixed little-endian word stream into instruction memory.
module im_program_loader
    import im_program_loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 14,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] base_addr,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  write,
    output logic [DATA_WIDTH-1:0] write_addr,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [DATA_WIDTH-1:0] word_count
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DATA_WIDTH:0] MEM_WORDS = (DATA_WIDTH + 1)'(1) << ADDR_WIDTH;

    state_e                state;
    logic [DATA_WIDTH-1:0] base_q;
    logic [DATA_WIDTH-1:0] total_q;
    logic [TMO_W-1:0]      tmo_q;

    logic                  xfer_c;
    logic                  start_c;
    logic                  word_done_c;
    logic [DATA_WIDTH-1:0] word_c;
    logic [DATA_WIDTH:0]   end_addr_c;

    assign xfer_c     = rx_valid && rx_ready;
    assign start_c    = start && !busy && (state == IDLE);
    assign end_addr_c = {1'b0, base_q} + {1'b0, word_c};

    im_program_loader_byte_word_assembler #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_assembler (
        .clock           (clock),
        .reset           (reset),
        .rx_byte         (rx_data),
        .strobe          (xfer_c),
        .clear           (start_c),
        .word_c          (word_c),
        .word_complete_c (word_done_c)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            base_q     <= '0;
            total_q    <= '0;
            tmo_q      <= '0;
            rx_ready   <= 1'b0;
            write      <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
        end else begin
            write <= 1'b0;
            done  <= 1'b0;

            // Idle watchdog while a stream is expected; a completing byte below overrides it.
            if (state != IDLE) begin
                if (xfer_c) begin
                    tmo_q <= '0;
                end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    error    <= 1'b1;
                    busy     <= 1'b0;
                    rx_ready <= 1'b0;
                    state    <= IDLE;
                end else begin
                    tmo_q <= tmo_q + TMO_W'(1);
                end
            end

            case (state)
                IDLE: begin
                    // busy lingers for the done cycle, so a start there is ignored
                    busy <= 1'b0;
                    if (start_c) begin
                        base_q     <= base_addr;
                        word_count <= '0;
                        error      <= 1'b0;
                        busy       <= 1'b1;
                        rx_ready   <= 1'b1;
                        tmo_q      <= '0;
                        state      <= HEADER;
                    end
                end
                HEADER: begin
                    if (word_done_c) begin
                        if (word_c == '0) begin
                            done     <= 1'b1;
                            rx_ready <= 1'b0;
                            state    <= IDLE;
                        end else if (end_addr_c > MEM_WORDS) begin
                            error    <= 1'b1;
                            busy     <= 1'b0;
                            rx_ready <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            total_q <= word_c;
                            state   <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (word_done_c) begin
                        write      <= 1'b1;
                        write_addr <= base_q + word_count;
                        write_data <= word_c;
                        word_count <= word_count + DATA_WIDTH'(1);
                        if (word_count + DATA_WIDTH'(1) == total_q) begin
                            done     <= 1'b1;
                            rx_ready <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
